// File: rtl/lcd_init_seq_if.sv
// Byte stream between a producer and the SPI byte engine:
// valid/ready handshake carrying one byte plus its D/C flag and end-of-transaction mark.
interface lcd_init_seq_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       dc;
  logic       last;

  modport master (output valid, data, dc, last, input ready);
  modport slave  (input valid, data, dc, last, output ready);
endinterface

// File: rtl/lcd_init_seq.sv
// LCD power-up sequencer: pulses the panel reset, streams a fixed command
// script into the SPI byte engine, then hands the engine to downstream logic.
module lcd_init_seq #(
  parameter int MS_DIV      = 36000,
  parameter int RST_LOW_MS  = 10,
  parameter int RST_WAIT_MS = 120,
  parameter int SLPOUT_MS   = 120,
  parameter int DISPON_MS   = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  output logic                  lcd_rst_o,
  lcd_init_seq_if.master        tx_if,
  lcd_init_seq_if.slave         usr_if,
  output logic                  done_o,
  output logic                  led_o,
  output logic [3:0]            step_o
);

  // The ms counter only has to reach the longest delay; the cycle counter
  // covers one ms. Together they span max(ms) x MS_DIV cycles.
  localparam int MAX_A  = (RST_LOW_MS > RST_WAIT_MS) ? RST_LOW_MS : RST_WAIT_MS;
  localparam int MAX_B  = (SLPOUT_MS > DISPON_MS) ? SLPOUT_MS : DISPON_MS;
  localparam int MAX_MS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MW     = (MAX_MS > 0) ? $clog2(MAX_MS + 1) : 1;
  localparam int CW     = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(MS_DIV - 1);

  typedef enum logic [2:0] {
    S_RST_LOW, S_RST_WAIT, S_FETCH, S_SEND, S_DELAY, S_DONE
  } state_t;

  typedef enum logic [1:0] {K_CMD, K_DATA, K_DELAY, K_END} kind_t;

  state_t          state_q;
  logic [3:0]      step_q;
  logic [CW-1:0]   cyc_q;
  logic [MW-1:0]   ms_q;
  logic            lcd_rst_q;
  logic            tx_valid_q;
  logic [7:0]      tx_byte_q;
  logic            tx_dc_q;
  logic            tx_last_q;
  logic            done_q;

  kind_t           rom_kind;
  logic [7:0]      rom_byte;
  logic            rom_last;
  logic [MW-1:0]   rom_ms;
  logic [MW-1:0]   tgt_ms;
  logic            timed;
  logic            tmr_done;

  // Script ROM indexed by the current step.
  always_comb begin
    rom_kind = K_END;
    rom_byte = 8'h00;
    rom_last = 1'b0;
    rom_ms   = '0;
    case (step_q)
      4'd0: begin rom_kind = K_CMD;   rom_byte = 8'h11; rom_last = 1'b1; end
      4'd1: begin rom_kind = K_DELAY; rom_ms   = MW'(SLPOUT_MS);         end
      4'd2: begin rom_kind = K_CMD;   rom_byte = 8'h3A;                  end
      4'd3: begin rom_kind = K_DATA;  rom_byte = 8'h05; rom_last = 1'b1; end
      4'd4: begin rom_kind = K_CMD;   rom_byte = 8'h36;                  end
      4'd5: begin rom_kind = K_DATA;  rom_byte = 8'h00; rom_last = 1'b1; end
      4'd6: begin rom_kind = K_CMD;   rom_byte = 8'h29; rom_last = 1'b1; end
      4'd7: begin rom_kind = K_DELAY; rom_ms   = MW'(DISPON_MS);         end
      default: ;
    endcase
  end

  // Length in ms of the wait belonging to the current state.
  always_comb begin
    tgt_ms = '0;
    timed  = 1'b1;
    case (state_q)
      S_RST_LOW:  tgt_ms = MW'(RST_LOW_MS);
      S_RST_WAIT: tgt_ms = MW'(RST_WAIT_MS);
      S_DELAY:    tgt_ms = rom_ms;
      default:    timed  = 1'b0;
    endcase
  end

  // Last cycle of the wait: N x MS_DIV cycles spent in the timed state.
  assign tmr_done = (tgt_ms == '0) ||
                    ((cyc_q == CYC_LAST) && (ms_q == tgt_ms - MW'(1)));

  // Sequencer: reset pulse, script walk, then permanent hand-off.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_RST_LOW;
      step_q     <= 4'd0;
      cyc_q      <= '0;
      ms_q       <= '0;
      lcd_rst_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      tx_dc_q    <= 1'b0;
      tx_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // Free-run the ms timer in timed states; hold it cleared elsewhere.
      if (!timed) begin
        cyc_q <= '0;
        ms_q  <= '0;
      end else if (cyc_q == CYC_LAST) begin
        cyc_q <= '0;
        ms_q  <= ms_q + MW'(1);
      end else begin
        cyc_q <= cyc_q + CW'(1);
      end

      case (state_q)
        S_RST_LOW: begin
          if (tmr_done) begin
            state_q   <= S_RST_WAIT;
            lcd_rst_q <= 1'b1;
            cyc_q     <= '0;
            ms_q      <= '0;
          end
        end
        S_RST_WAIT: begin
          if (tmr_done) begin
            state_q <= S_FETCH;
            step_q  <= 4'd0;
          end
        end
        S_FETCH: begin
          case (rom_kind)
            K_CMD, K_DATA: begin
              state_q    <= S_SEND;
              tx_valid_q <= 1'b1;
              tx_byte_q  <= rom_byte;
              tx_dc_q    <= (rom_kind == K_DATA);
              tx_last_q  <= rom_last;
            end
            K_DELAY: begin
              if (rom_ms == '0) begin
                step_q <= step_q + 4'd1;
              end else begin
                state_q <= S_DELAY;
                cyc_q   <= '0;
                ms_q    <= '0;
              end
            end
            default: begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          endcase
        end
        S_SEND: begin
          // Byte fields stay frozen until the engine takes the byte.
          if (tx_if.ready) begin
            tx_valid_q <= 1'b0;
            step_q     <= step_q + 4'd1;
            state_q    <= S_FETCH;
          end
        end
        S_DELAY: begin
          if (tmr_done) begin
            step_q  <= step_q + 4'd1;
            state_q <= S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  // After DONE the engine is driven straight from the downstream source.
  assign tx_if.valid  = done_q ? usr_if.valid : tx_valid_q;
  assign tx_if.data   = done_q ? usr_if.data  : tx_byte_q;
  assign tx_if.dc     = done_q ? usr_if.dc    : tx_dc_q;
  assign tx_if.last   = done_q ? usr_if.last  : tx_last_q;
  assign usr_if.ready = done_q & tx_if.ready;

  assign lcd_rst_o = lcd_rst_q;
  assign done_o    = done_q;
  assign led_o     = done_q;
  assign step_o    = step_q;

endmodule

// File: tb/tb_lcd_init_seq.sv
// Bench for lcd_init_seq: directed tables for power-up, hand-off and resets,
// then random back-pressure, downstream traffic and resets against a schedule model.
module tb_lcd_init_seq;
  localparam int D = 4;   // MS_DIV
  localparam int L = 1;   // RST_LOW_MS
  localparam int W = 2;   // RST_WAIT_MS
  localparam int S = 3;   // SLPOUT_MS
  localparam int P = 2;   // DISPON_MS

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_init_seq_if tx_if ();
  lcd_init_seq_if usr_if ();
  logic       lcd_rst, done, led;
  logic [3:0] step;

  lcd_init_seq #(
    .MS_DIV(D), .RST_LOW_MS(L), .RST_WAIT_MS(W), .SLPOUT_MS(S), .DISPON_MS(P)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .lcd_rst_o(lcd_rst),
    .tx_if(tx_if), .usr_if(usr_if),
    .done_o(done), .led_o(led), .step_o(step)
  );

  typedef enum int {M_BYTE, M_DELAY, M_END} mkind_t;
  typedef struct { mkind_t kind; logic [7:0] b; logic dc; logic last; int ms; } item_t;
  typedef struct { logic [7:0] b; logic dc; logic last; int k; } acc_t;
  typedef struct {
    logic uv; logic [7:0] ub; logic udc; logic ul; logic rdy;
    logic e_v; logic [7:0] e_b; logic e_dc; logic e_l; logic e_ur;
  } pt_t;

  item_t script [9];
  acc_t  acc_tab [6];
  pt_t   pt_tab [5];
  acc_t  acc_q [$];

  int vectors = 0;
  int miscompares = 0;

  // Schedule model: sample index since reset, item being worked on, sample
  // at which that item is fetched, and whether a byte is being offered.
  int m_k, m_item, m_fetch;
  bit m_offer, m_dpend, m_done, m_rst;

  logic       obs_valid, obs_done, obs_dc, obs_last;
  logic [7:0] obs_byte;
  int         rise_k, fv_k;
  bit         aa_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_item = 0; m_fetch = (L + W) * D;
    m_offer = 0; m_dpend = 0; m_done = 0; m_rst = 1;
  endtask

  task automatic model_advance(input bit rdy);
    m_rst = 0;
    if (!m_done) begin
      if (m_k == m_fetch) begin
        case (script[m_item].kind)
          M_BYTE:  m_offer = 1;
          M_DELAY: begin m_fetch = m_k + 1 + script[m_item].ms * D; m_dpend = 1; end
          default: m_done = 1;
        endcase
      end else if (m_offer && rdy) begin
        m_offer = 0; m_item++; m_fetch = m_k + 1;
      end
    end
    m_k++;
    if (m_dpend && m_k == m_fetch) begin m_item++; m_dpend = 0; end
  endtask

  task automatic model_compare();
    logic [18:0] e, a, msk;
    logic ev, edc, el, eur, elcd;
    logic [7:0] eb;
    elcd = !m_rst && (m_k >= L * D);
    if (m_done) begin
      ev = usr_if.valid; eb = usr_if.data; edc = usr_if.dc; el = usr_if.last; eur = tx_if.ready;
    end else if (m_offer) begin
      ev = 1'b1; eb = script[m_item].b; edc = script[m_item].dc; el = script[m_item].last; eur = 1'b0;
    end else begin
      ev = 1'b0; eb = 8'h00; edc = 1'b0; el = 1'b0; eur = 1'b0;
    end
    e = {elcd, ev, m_done, m_done, eur, 4'(m_item), edc, el, eb};
    a = {lcd_rst, tx_if.valid, done, led, usr_if.ready, step, tx_if.dc, tx_if.last, tx_if.data};
    msk = (m_done || m_offer || m_rst) ? 19'h7FFFF : 19'h7FC00;
    check("cycle", 32'(a & msk), 32'(e & msk));
  endtask

  // One clock: note any handshake on the coming edge, then check outputs.
  task automatic tick();
    bit rst_e, rdy_e;
    rst_e = rst_n;
    rdy_e = tx_if.ready;
    if (rst_e && obs_valid && !obs_done && rdy_e) begin
      acc_q.push_back('{obs_byte, obs_dc, obs_last, m_k});
      $display("xfer k=%0d byte=%02h dc=%0d last=%0d", m_k, obs_byte, obs_dc, obs_last);
    end
    @(posedge clk);
    #1;
    if (!rst_e) model_reset(); else model_advance(rdy_e);
    model_compare();
    if (!rst_e) begin rise_k = -1; fv_k = -1; end
    if (rise_k < 0 && lcd_rst) rise_k = m_k;
    if (fv_k < 0 && tx_if.valid) fv_k = m_k;
    if (!done && tx_if.data == 8'hAA) aa_seen = 1;
    obs_valid = tx_if.valid; obs_byte = tx_if.data; obs_dc = tx_if.dc;
    obs_last = tx_if.last; obs_done = done;
  endtask

  task automatic check_reset_sample(input string tag);
    check(tag, {lcd_rst, tx_if.valid, done, led, step, usr_if.ready, tx_if.data}, 32'h0);
  endtask

  // Run the whole script with TX_READY high and compare against the table.
  task automatic run_script(input string tag);
    int n;
    n = 0;
    acc_q.delete();
    while (!obs_done && n < 400) begin tick(); n++; end
    check({tag, "_done"}, {31'h0, obs_done}, 32'h1);
    check({tag, "_count"}, acc_q.size(), 6);
    for (int i = 0; i < 6 && i < acc_q.size(); i++)
      check({tag, "_xfer"}, {acc_q[i].b, acc_q[i].dc, acc_q[i].last, 16'(acc_q[i].k)},
            {acc_tab[i].b, acc_tab[i].dc, acc_tab[i].last, 16'(acc_tab[i].k)});
    // fetch0 at 12, 0x11 (2), SLPOUT (1+12), four bytes (8), 0x29 (2),
    // DISPON (1+8), END fetch (1): DONE first seen at sample 47
    check({tag, "_done_k"}, m_k, 47);
    check({tag, "_end"}, {step, led}, {4'd8, 1'b1});
  endtask

  initial begin
    int n;
    bit found;

    script[0] = '{M_BYTE,  8'h11, 1'b0, 1'b1, 0};
    script[1] = '{M_DELAY, 8'h00, 1'b0, 1'b0, S};
    script[2] = '{M_BYTE,  8'h3A, 1'b0, 1'b0, 0};
    script[3] = '{M_BYTE,  8'h05, 1'b1, 1'b1, 0};
    script[4] = '{M_BYTE,  8'h36, 1'b0, 1'b0, 0};
    script[5] = '{M_BYTE,  8'h00, 1'b1, 1'b1, 0};
    script[6] = '{M_BYTE,  8'h29, 1'b0, 1'b1, 0};
    script[7] = '{M_DELAY, 8'h00, 1'b0, 1'b0, P};
    script[8] = '{M_END,   8'h00, 1'b0, 1'b0, 0};

    acc_tab[0] = '{8'h11, 1'b0, 1'b1, 13};
    acc_tab[1] = '{8'h3A, 1'b0, 1'b0, 28};
    acc_tab[2] = '{8'h05, 1'b1, 1'b1, 30};
    acc_tab[3] = '{8'h36, 1'b0, 1'b0, 32};
    acc_tab[4] = '{8'h00, 1'b1, 1'b1, 34};
    acc_tab[5] = '{8'h29, 1'b0, 1'b1, 36};

    pt_tab[0] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1,  1'b1, 8'h5A, 1'b1, 1'b0, 1'b1};
    pt_tab[1] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0,  1'b1, 8'h5A, 1'b1, 1'b0, 1'b0};
    pt_tab[2] = '{1'b0, 8'hC3, 1'b0, 1'b1, 1'b1,  1'b0, 8'hC3, 1'b0, 1'b1, 1'b1};
    pt_tab[3] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0,  1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    pt_tab[4] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1,  1'b1, 8'hFF, 1'b1, 1'b1, 1'b1};

    tx_if.ready = 1'b1;
    usr_if.valid = 1'b0; usr_if.data = 8'h00; usr_if.dc = 1'b0; usr_if.last = 1'b0;
    obs_valid = 0; obs_done = 0; obs_byte = 0; obs_dc = 0; obs_last = 0;
    rise_k = -1; fv_k = -1; aa_seen = 0;
    model_reset();

    // Power-up timing and full script
    rst_n = 1'b0; tick();
    check_reset_sample("reset");
    rst_n = 1'b1;
    run_script("powerup");
    check("lcd_rise_k", rise_k, L * D);
    check("first_valid_k", fv_k, (L + W) * D + 1);

    // Hand-off pass-through table
    for (int i = 0; i < 5; i++) begin
      usr_if.valid = pt_tab[i].uv; usr_if.data = pt_tab[i].ub;
      usr_if.dc = pt_tab[i].udc; usr_if.last = pt_tab[i].ul; tx_if.ready = pt_tab[i].rdy;
      #1;
      check("passthru", {tx_if.valid, tx_if.data, tx_if.dc, tx_if.last, usr_if.ready},
            {pt_tab[i].e_v, pt_tab[i].e_b, pt_tab[i].e_dc, pt_tab[i].e_l, pt_tab[i].e_ur});
      tick();
    end
    tx_if.ready = 1'b1; usr_if.valid = 1'b0;

    // Reset during the SLPOUT delay, then again after DONE
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("in_slpout", {step, tx_if.valid, lcd_rst}, {4'd1, 1'b0, 1'b1});
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_reset_sample("rst_in_delay");
    run_script("rerun1");
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_reset_sample("rst_in_done");
    run_script("rerun2");

    // Back-pressure on 0x3A with downstream 0xAA held valid before DONE
    usr_if.valid = 1'b1; usr_if.data = 8'hAA; usr_if.dc = 1'b0; usr_if.last = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    acc_q.delete(); aa_seen = 0; found = 0; n = 0;
    while (!found && n < 100) begin
      tick(); n++;
      if (obs_valid && obs_byte == 8'h3A) found = 1;
    end
    check("bp_found", {31'h0, found}, 32'h1);
    tx_if.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", {tx_if.valid, tx_if.data, tx_if.dc, tx_if.last, usr_if.ready},
            {1'b1, 8'h3A, 1'b0, 1'b0, 1'b0});
    end
    tx_if.ready = 1'b1;
    n = 0;
    while (!obs_done && n < 400) begin tick(); n++; end
    check("bp_done", {31'h0, obs_done}, 32'h1);
    check("bp_count", acc_q.size(), 6);
    for (int i = 0; i < 6 && i < acc_q.size(); i++)
      check("bp_xfer", {acc_q[i].b, acc_q[i].dc, acc_q[i].last},
            {acc_tab[i].b, acc_tab[i].dc, acc_tab[i].last});
    check("gate_aa", {31'h0, aa_seen}, 32'h0);

    // Random back-pressure, downstream traffic and occasional resets
    for (int c = 0; c < 3000; c++) begin
      tx_if.ready  = ($urandom_range(0, 3) != 0);
      usr_if.valid = $urandom_range(0, 1);
      usr_if.data  = 8'($urandom);
      usr_if.dc    = $urandom_range(0, 1);
      usr_if.last  = $urandom_range(0, 1);
      rst_n        = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
